// File: rtl/ccff_loader_pkg.sv
// Shared FSM state type and pass sizing for the ccff chain loader.
// A pass is rounded up to whole words; surplus low-order bits of the last word are dropped.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    VERIFY,
    DONE
  } state_e;

  function automatic int words_per_pass(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word register + MSB-first shifter; next bit is visible combinationally on bit_dat_o.
// Ready is raised while the last bit of the held word drains, so words chain with no bubble.
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 21,
  parameter int WORD_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              pass_start_i,
  input  logic              active_i,
  input  logic [WORD_W-1:0] cfg_data_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  output logic              bit_vld_o,
  output logic              bit_dat_o
);

  localparam int WPP       = words_per_pass(CHAIN_LEN, WORD_W);
  localparam int WL_W      = $clog2(WPP + 1);
  localparam int BL_W      = $clog2(WORD_W + 1);
  localparam int LAST_BITS = CHAIN_LEN - (WPP - 1) * WORD_W;

  logic [WORD_W-1:0] word_q, word_d;
  logic [BL_W-1:0]   bits_left_q, bits_left_d;
  logic [WL_W-1:0]   words_left_q, words_left_d;
  logic              accept;

  assign cfg_ready_o = active_i && (words_left_q != '0) && (bits_left_q <= BL_W'(1));
  assign accept      = cfg_valid_i && cfg_ready_o;
  assign bit_vld_o   = (bits_left_q != '0);
  assign bit_dat_o   = word_q[WORD_W-1];

  always_comb begin
    word_d       = word_q;
    bits_left_d  = bits_left_q;
    words_left_d = words_left_q;
    if (bit_vld_o) begin
      word_d      = word_q << 1;
      bits_left_d = bits_left_q - BL_W'(1);
    end
    // A new word can land on the same edge the final bit of the old one leaves.
    if (accept) begin
      word_d       = cfg_data_i;
      bits_left_d  = (words_left_q == WL_W'(1)) ? BL_W'(LAST_BITS) : BL_W'(WORD_W);
      words_left_d = words_left_q - WL_W'(1);
    end
    if (clear_i) begin
      bits_left_d  = '0;
      words_left_d = '0;
    end else if (pass_start_i) begin
      bits_left_d  = '0;
      words_left_d = WL_W'(WPP);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q       <= '0;
      bits_left_q  <= '0;
      words_left_q <= '0;
    end else begin
      word_q       <= word_d;
      bits_left_q  <= bits_left_d;
      words_left_q <= words_left_d;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a tile's ccff scan chain bit-serially, with an optional read-back verify pass.
// Word accepted at edge t drives its MSB on ccff_head (clk_en=1) after edge t+1; starved cycles freeze the chain.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int  CHAIN_LEN = 21,
  parameter int  WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              verify_en,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  err_bit_idx
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] err_idx_q, err_idx_d;
  logic             verify_q, verify_d;
  logic             head_q, head_d;
  logic             clk_en_q, clk_en_d;
  logic             err_q, err_d;
  logic             pass_start, clear, active, last_bit;
  logic             ser_vld, ser_dat;

  assign active   = (state_q == SHIFT) || (state_q == VERIFY);
  assign clear    = abort && (state_q != IDLE);
  assign last_bit = clk_en_q && (cnt_q == CNT_W'(CHAIN_LEN - 1));

  ccff_word_serializer #(
    .CHAIN_LEN(CHAIN_LEN),
    .WORD_W   (WORD_W)
  ) u_ser (
    .clk_i       (prog_clk),
    .rst_i       (prog_reset),
    .clear_i     (clear),
    .pass_start_i(pass_start),
    .active_i    (active),
    .cfg_data_i  (cfg_data),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .bit_vld_o   (ser_vld),
    .bit_dat_o   (ser_dat)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    verify_d   = verify_q;
    head_d     = head_q;
    clk_en_d   = 1'b0;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    pass_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d    = SHIFT;
          verify_d   = verify_en;
          cnt_d      = '0;
          err_d      = 1'b0;
          err_idx_d  = '0;
          pass_start = 1'b1;
        end
      end
      SHIFT, VERIFY: begin
        if (ser_vld) begin
          head_d   = ser_dat;
          clk_en_d = 1'b1;
        end
        // cnt_q is the shift-order index of the bit currently on ccff_head.
        if (clk_en_q) begin
          cnt_d = cnt_q + CNT_W'(1);
          if ((state_q == VERIFY) && (ccff_tail != head_q) && !err_q) begin
            err_d     = 1'b1;
            err_idx_d = cnt_q;
          end
        end
        if (last_bit) begin
          cnt_d = '0;
          if ((state_q == SHIFT) && verify_q) begin
            state_d    = VERIFY;
            pass_start = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d    = IDLE;
      cnt_d      = '0;
      head_d     = 1'b0;
      clk_en_d   = 1'b0;
      err_d      = err_q;
      err_idx_d  = err_idx_q;
      pass_start = 1'b0;
    end
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      verify_q  <= 1'b0;
      head_q    <= 1'b0;
      clk_en_q  <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      verify_q  <= verify_d;
      head_q    <= head_d;
      clk_en_q  <= clk_en_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign ccff_head   = head_q;
  assign ccff_clk_en = clk_en_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign error       = err_q;
  assign err_bit_idx = err_idx_q;

endmodule
